// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus bundling hazard controls, redirect targets, instruction port and IF/ID outputs
// Ports (signals):
//   PCSrc, PC_wen, IF_wen, IF_Flush        next-PC select and hazard-unit enables
//   branch_target, jump_index, jr_target   redirect sources from ID
//   inst_addr / inst_data                  combinational instruction memory port
//   PC, IF_ID_PC, IF_ID_PC_plus4,
//   IF_ID_Instruction, IF_ID_valid         fetch state seen by the rest of the pipe
// Modports: master = pipeline/memory side, slave = if_stage
interface if_stage_if;
    logic [2:0]  PCSrc;
    logic        PC_wen;
    logic        IF_wen;
    logic        IF_Flush;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] inst_data;
    logic [31:0] inst_addr;
    logic [31:0] PC;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC_plus4;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_valid;

    modport master (
        output PCSrc, PC_wen, IF_wen, IF_Flush, branch_target, jump_index, jr_target, inst_data,
        input  inst_addr, PC, IF_ID_PC, IF_ID_PC_plus4, IF_ID_Instruction, IF_ID_valid
    );

    modport slave (
        input  PCSrc, PC_wen, IF_wen, IF_Flush, branch_target, jump_index, jr_target, inst_data,
        output inst_addr, PC, IF_ID_PC, IF_ID_PC_plus4, IF_ID_Instruction, IF_ID_valid
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: PC register, next-PC selection and IF/ID pipeline register
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    if_stage_if.slave carrying controls, redirect targets, instruction port and IF/ID outputs
module if_stage (
    input  logic        clk,
    input  logic        reset,
    if_stage_if.slave   bus
);
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
    localparam logic [31:0] XADR_PC  = 32'h8000_0008;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] jump_target;
    logic [31:0] jr_safe;
    logic        exc_redirect;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    // Increment never touches the kernel bit; the low 31 bits wrap on their own.
    assign pc_plus4    = {pc[31], pc[30:0] + 31'd4};
    assign jump_target = {if_id_pc_plus4[31:28], bus.jump_index, 2'b00};
    // JR/JALR keeps the privilege level of the jumping instruction, so user code cannot reach kernel space.
    assign jr_safe     = {if_id_pc[31], bus.jr_target[30:0]};
    // Exception redirects must win over a hazard-unit stall of the PC.
    assign exc_redirect = (bus.PCSrc == 3'b011) || (bus.PCSrc == 3'b100);

    always_comb begin
        next_pc = pc_plus4;
        case (bus.PCSrc)
            3'b001:  next_pc = bus.branch_target;
            3'b010:  next_pc = jump_target;
            3'b011:  next_pc = ILLOP_PC;
            3'b100:  next_pc = XADR_PC;
            3'b101:  next_pc = jr_safe;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_PC;
        else if (bus.PC_wen || exc_redirect)
            pc <= next_pc;
    end

    // Flush outranks a stall so a squashed slot always becomes a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_pc       <= RESET_PC;
            if_id_pc_plus4 <= ILLOP_PC;
            if_id_instr    <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (bus.IF_Flush) begin
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_instr    <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (bus.IF_wen) begin
            if_id_pc       <= pc;
            if_id_pc_plus4 <= pc_plus4;
            if_id_instr    <= bus.inst_data;
            if_id_valid    <= 1'b1;
        end
    end

    assign bus.inst_addr         = pc;
    assign bus.PC                = pc;
    assign bus.IF_ID_PC          = if_id_pc;
    assign bus.IF_ID_PC_plus4    = if_id_pc_plus4;
    assign bus.IF_ID_Instruction = if_id_instr;
    assign bus.IF_ID_valid       = if_id_valid;
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL provide: PCSrc  input  3  next-PC select; 000 PC+4, 001 branch, 010 jump, 011 ILLOP, 100 XADR, 101 register (JR/JALR), 110/111 treated as 000.
REQ-004 SHALL provide: PC_wen  input  1  PC write enable from hazard unit.
REQ-005 SHALL provide: IF_wen  input  1  IF/ID register write enable from hazard unit.
REQ-006 SHALL provide: IF_Flush  input  1  squash the instruction being latched into IF/ID.
REQ-007 SHALL provide: branch_target  input  32  branch target computed in ID.
REQ-008 SHALL provide: jump_index  input  26  J/JAL instr_index field from IF/ID.
REQ-009 SHALL provide: jr_target  input  32  forwarded register value for JR/JALR.
REQ-010 SHALL provide: inst_data  input  32  instruction word returned combinationally for inst_addr.
REQ-011 SHALL provide: inst_addr  output  32  fetch address, equal to PC.
REQ-012 SHALL provide: PC  output  32  current PC register.
REQ-013 SHALL provide: IF_ID_PC  output  32  PC of instruction held in IF/ID.
REQ-014 SHALL provide: IF_ID_PC_plus4  output  32  link/next address of held instruction.
REQ-015 SHALL provide: IF_ID_Instruction  output  32  held instruction word.
REQ-016 SHALL provide: IF_ID_valid  output  1  1 = held instruction is real, 0 = bubble.

Function
REQ-017 PC_plus4 SHALL be {PC[31], PC[30:0] + 4}; the kernel bit PC[31] is never changed by increment; bits 30:0 wrap 0x7FFFFFFC -> 0x00000000.
REQ-018 Jump target SHALL be {IF_ID_PC_plus4[31:28], jump_index, 2'b00}.
REQ-019 Next PC SHALL be: 000 PC_plus4; 001 branch_target; 010 jump target; 011 0x80000004; 100 0x80000008; 101 jr_target with bit 31 forced to IF_ID_PC[31] (user code cannot enter kernel via JR); 110/111 PC_plus4.
REQ-020 PC SHALL load next PC on a clock edge when PC_wen=1, or when PCSrc is 011/100 regardless of PC_wen; otherwise it holds.
REQ-021 inst_addr SHALL equal PC combinationally; fetch latency is zero cycles, with the instruction latched into IF/ID on the next edge.
REQ-022 IF/ID SHALL update on a clock edge per priority: IF_Flush=1 -> Instruction 0x00000000, valid 0, PC/PC_plus4 loaded from current PC/PC_plus4; else IF_wen=1 -> Instruction inst_data, valid 1, PC, PC_plus4; else hold all fields.
REQ-023 IF_Flush SHALL take priority over IF_wen=0: flush during a load-use stall inserts a bubble.
REQ-024 A stall with PC_wen=0 and IF_wen=0 SHALL hold PC and IF/ID indefinitely with no fetch-side side effects.
REQ-025 Exception redirect (011/100) together with IF_wen=0 SHALL update PC while IF/ID holds.
REQ-026 No combinational path SHALL exist from any input to PC, IF_ID_* outputs; only inst_addr is derived combinationally, and only from PC.

Reset
REQ-027 On reset=0, asynchronously: PC=0x80000000, IF_ID_PC=0x80000000, IF_ID_PC_plus4=0x80000004, IF_ID_Instruction=0x00000000, IF_ID_valid=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL override all inputs immediately; the first fetch after release SHALL be from 0x80000000 on the first rising edge with reset=1.
REQ-029 Reset release SHALL be synchronised by the system; the block SHALL reach no state other than the REQ-027 state while reset=0.

Verification
REQ-030 Release reset, PCSrc=000, PC_wen=IF_wen=1, inst_data=0x24080001 -> after 1 edge IF_ID_Instruction=0x24080001, IF_ID_PC=0x80000000, valid=1, PC=0x80000004.
REQ-031 Load-use: PC_wen=IF_wen=0 for 1 cycle at PC=0x00400010 -> PC and IF/ID unchanged that edge; next edge resumes at 0x00400014.
REQ-032 Branch: PCSrc=001, branch_target=0x00400040, IF_Flush=1 -> PC=0x00400040, IF_ID_Instruction=0, valid=0.
REQ-033 Jump: IF_ID_PC_plus4=0x00400008, jump_index=0x0100020, PCSrc=010 -> PC=0x00400080; JR with IF_ID_PC=0x00400000, jr_target=0x80001000 -> PC=0x00001000.
REQ-034 Exception: PCSrc=011 with PC_wen=0, IF_wen=0 -> PC=0x80000004, IF/ID held; PCSrc=100 -> PC=0x80000008.
REQ-035 Async reset: drive reset=0 between edges during a stall -> outputs match REQ-027 before the next edge; PC=0x7FFFFFFC, PCSrc=000 -> PC=0x00000000.
